// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Sequencer around an external 4-bit ripple adder. Adds or subtracts two
// W = 4*NIBBLES bit operands one nibble per cycle, LSB nibble first, chaining
// the carry between nibbles. Subtraction feeds ~B with carry-in 1.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, sub            request (accepted in IDLE) and add/subtract select
//   op_a, op_b            W-bit operands, sampled with start
//   busy, done            busy in RUN/DONE; done is a one-cycle result strobe
//   result, carry_out,    full-width result, final carry (sub: 1 = no borrow)
//   overflow              and signed overflow, held until next accepted start
//   add_a, add_b, add_cin combinational drive to the adder (zero outside RUN)
//   add_sum, add_cout,    adder outputs; add_ovf is only meaningful on the
//   add_ovf               top nibble
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout,
  input  logic                 add_ovf
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Adder drive: current nibble of the latched operands while running.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_cin = c_q;
      for (int unsigned n = 0; n < NIBBLES; n++) begin
        if (idx_q == IDX_W'(n)) begin
          add_a = a_q[4*n +: 4];
          add_b = b_q[4*n +: 4];
        end
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    idx_d    = idx_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = op_a;
          b_d      = sub ? ~op_b : op_b;
          c_d      = sub;  // +1 of the two's complement for subtraction
          idx_d    = '0;
          result_d = '0;
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            result_d[4*n +: 4] = add_sum;
          end
        end
        c_d = add_cout;
        if (idx_q == IDX_LAST) begin
          carry_d = add_cout;
          ovf_d   = add_ovf;
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule
